// File: rtl/key_search_pkg.sv
// key_search_pkg: shared types and constants for the key search controller.
// Contents: FSM state enum, default LENGTH/DEPTH, idx_w() index-width helper.
package key_search_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
    localparam int DEF_LENGTH = 22;
    localparam int DEF_DEPTH  = 8;
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/key_search_ctrl_comparator.sv
// comparator: single LENGTH-bit equality comparator shared by the whole table scan.
// Ports: a, b - operands; eq - high when a == b.
module comparator #(
    parameter int LENGTH = 22
) (
    input  logic [LENGTH-1:0] a,
    input  logic [LENGTH-1:0] b,
    output logic              eq
);
    assign eq = (a == b);
endmodule

// File: rtl/key_search_ctrl.sv
// key_search_ctrl: sequential key-match engine scanning a DEPTH-entry table one entry per cycle.
// Ports: clk, rst_n (async, active-low); wr_en/wr_idx/wr_key table write; clr invalidate all;
//        req_valid/req_ready/req_key query handshake; rsp_valid/rsp_ready/rsp_hit/rsp_idx/rsp_multi result.
// Macro: KEY_SEARCH_MULTIHIT_EN - full-depth scan with multi-match reporting; undefined exits on first match.
module key_search_ctrl
    import key_search_pkg::*;
#(
    parameter  int LENGTH = DEF_LENGTH,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int IDX_W  = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [LENGTH-1:0] wr_key,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LENGTH-1:0] req_key,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic              rsp_multi
);
`ifdef KEY_SEARCH_MULTIHIT_EN
    localparam bit EARLY_EXIT = 1'b0;
`else
    localparam bit EARLY_EXIT = 1'b1;
`endif
    state_e            state_q, state_d;
    logic [LENGTH-1:0] keys_q [DEPTH];
    logic [LENGTH-1:0] keys_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [LENGTH-1:0] qkey_q, qkey_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d, idx_q, idx_d;
    logic              hit_q, hit_d;
    logic              eq, match, last, accept;
`ifdef KEY_SEARCH_MULTIHIT_EN
    logic              multi_q, multi_d;
    assign rsp_multi = multi_q;
`else
    assign rsp_multi = 1'b0;
`endif

    comparator #(.LENGTH(LENGTH)) u_cmp (
        .a  (qkey_q),
        .b  (keys_q[ptr_q]),
        .eq (eq)
    );

    assign match   = eq && valid_q[ptr_q];
    assign last    = (ptr_q == IDX_W'(DEPTH - 1));
    assign accept  = req_valid && req_ready;
    assign rsp_hit = hit_q;
    assign rsp_idx = idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCAN;
            SCAN:    if (last || (EARLY_EXIT && match)) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == DONE);
    end

    // clr is applied before the write so a same-cycle write survives the clear
    always_comb begin
        valid_d = clr ? '0 : valid_q;
        keys_d  = keys_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            keys_d[wr_idx]  = wr_key;
        end
        qkey_d = qkey_q;
        ptr_d  = ptr_q;
        hit_d  = hit_q;
        idx_d  = idx_q;
`ifdef KEY_SEARCH_MULTIHIT_EN
        multi_d = multi_q;
`endif
        if (accept) begin
            qkey_d = req_key;
            ptr_d  = '0;
            hit_d  = 1'b0;
            idx_d  = '0;
`ifdef KEY_SEARCH_MULTIHIT_EN
            multi_d = 1'b0;
`endif
        end
        if (state_q == SCAN) begin
            ptr_d = last ? ptr_q : ptr_q + IDX_W'(1);
            // only the first match records the index, giving the lowest one
            if (match && !hit_q) begin
                hit_d = 1'b1;
                idx_d = ptr_q;
            end
`ifdef KEY_SEARCH_MULTIHIT_EN
            if (match && hit_q) multi_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            qkey_q  <= '0;
            ptr_q   <= '0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
`ifdef KEY_SEARCH_MULTIHIT_EN
            multi_q <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            qkey_q  <= qkey_d;
            ptr_q   <= ptr_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
`ifdef KEY_SEARCH_MULTIHIT_EN
            multi_q <= multi_d;
`endif
        end
    end

    // key storage is intentionally not reset; valid bits gate every compare
    always_ff @(posedge clk) begin
        keys_q <= keys_d;
    end
endmodule

// File: doc/key_search_ctrl.md
# key_search_ctrl

Sequential key-match controller that time-shares one LENGTH-bit equality comparator across a DEPTH-entry key table. A requester presents a query key; the block scans the table one entry per cycle and returns hit/miss plus the matching index. It is the lookup engine in front of the key/tag datapath and owns the only comparator instance.

## Interface
- LENGTH, 22, key width in bits
- DEPTH, 8, table entries (≥2); IDX_W = $clog2(DEPTH)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write table entry this cycle
- wr_idx  in  IDX_W  entry to write
- wr_key  in  LENGTH  key value written; the entry becomes valid
- clr  in  1  invalidate all entries
- req_valid  in  1  query present
- req_ready  out  1  block accepts a query (high only in IDLE)
- req_key  in  LENGTH  query key, captured on accept
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer takes the result
- rsp_hit  out  1  a valid entry matched
- rsp_idx  out  IDX_W  lowest matching index; 0 on miss
- rsp_multi  out  1  more than one valid match (macro-dependent, see Configuration)

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_key, ptr←0, go to SCAN.
- SCAN: the comparator compares the latched key against key[ptr]; match = eq && valid[ptr]. On the first match, record ptr and go to DONE with hit=1. If ptr==DEPTH-1 with no match, go to DONE with hit=0 and idx=0. Otherwise ptr←ptr+1.
- DONE: rsp_valid=1. rsp_hit, rsp_idx and rsp_multi stay stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE.
- Table writes and clr are accepted in every state. Each compare uses the registered table contents for that cycle, so a write or clear lands one cycle later.
- If wr_en and clr arrive in the same cycle, clr applies first and the written entry ends up valid.
- req_valid outside IDLE is ignored. No queuing.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_hit=0, rsp_idx=0, rsp_multi=0, all valid bits 0. Key storage is not reset.
- Asserting rst_n low mid-scan or in DONE aborts the operation immediately. The pending result is lost.

## Timing
- Accept edge = E0. A hit at index k sets rsp_valid after edge E0+k+1.
- A miss sets rsp_valid after E0+DEPTH.
- DONE→IDLE on the handshake edge. req_ready is high the next cycle.
- Minimum query-to-query period is latency+2 cycles.
- ptr never wraps. The scan terminates at DEPTH-1.

## Configuration
- KEY_SEARCH_MULTIHIT_EN defined:
  - The scan always runs all DEPTH entries; latency is DEPTH cycles for both hit and miss.
  - rsp_idx reports the lowest matching index.
  - rsp_multi=1 when two or more valid entries match.
- Undefined:
  - The scan exits early on the first match.
  - rsp_multi is tied to 0.

## Structure
- Package key_search_pkg holds:
  - the state enum (IDLE/SCAN/DONE)
  - default LENGTH/DEPTH constants
  - the IDX_W helper
- One sub-module: comparator #(.LENGTH(LENGTH)), instanced once. Its eq output is qualified by valid[ptr] in the controller.
- The table (key array plus valid vector), ptr, and FSM live in key_search_ctrl.

## Test plan
- Reset then query 22'h0 with no writes -> miss: rsp_hit=0, rsp_idx=0, rsp_valid 8 cycles after accept. Outputs at reset values while rst_n is low.
- Write entry 5=22'h2A5A5, query 22'h2A5A5 -> rsp_hit=1, rsp_idx=5. rsp_valid 6 cycles after accept without the macro, 8 cycles with it.
- Entries 2 and 6 both 22'h00F0F, query 22'h00F0F:
  - without the macro -> idx=2 at 3 cycles, rsp_multi=0
  - with the macro -> idx=2 at 8 cycles, rsp_multi=1
- Hold rsp_ready=0 for 5 cycles in DONE -> rsp_* stable and req_ready=0. A req_valid pulse is ignored. Release -> IDLE the next cycle.
- Key at entry 4; pulse clr while ptr=1 -> miss. A write with clr in the same cycle -> that entry still valid.
- Drop rst_n mid-SCAN -> rsp_valid=0 immediately. After release, req_ready=1 and all entries invalid.
